// File: rtl/seg7_scan_capture_pkg.sv
// Shared segment code table and helpers for the 7-segment scan capture block.
// Segment lines are active-low, bit0 = a .. bit6 = g.
package seg7_scan_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    OutLegal,
    OutBlank,
    OutIllegal
  } outcome_e;

  function automatic outcome_e classify(input logic legal, input logic is_blank);
    if (legal) begin
      return OutLegal;
    end else if (is_blank) begin
      return OutBlank;
    end
    return OutIllegal;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse decoder: active-low segment pattern back to a hex nibble.
// Only the exact 16 codes of the shared table are legal; all-off is reported separately.
module seg7_to_hex
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       legal,
  output logic       is_blank
);

  always_comb begin
    hex      = 4'h0;
    legal    = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: begin
        legal    = 1'b0;
        is_blank = (seg == SEG_BLANK);
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive end of a multiplexed 7-segment bus: synchronises the segment/digit pair, waits for
// a stable episode, then decodes and latches one digit per episode.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     dig_n,
  output logic [4*NDIG-1:0]   hex,
  output logic [NDIG-1:0]     valid,
  output logic [NDIG-1:0]     blank,
  output logic [NDIG-1:0]     err,
  output logic                upd,
  output logic                frame
);

  localparam int unsigned PW = 7 + NDIG;
  localparam int unsigned CW = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CntMax = CW'(STABLE_CYC - 1);

  logic [PW-1:0]     sync_q, pair_q;
  logic [6:0]        pair_seg;
  logic [NDIG-1:0]   pair_dig;
  logic              changed;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [3:0]        n_low;
  logic              one_low;
  logic              accept;

  logic [3:0]        dec_hex;
  logic              dec_legal;
  logic              dec_blank;
  outcome_e          outcome;

  logic [4*NDIG-1:0] hex_q, hex_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic [NDIG-1:0]   blank_q, blank_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic [NDIG-1:0]   seen_q, seen_d, seen_set;
  logic              upd_q, upd_d;
  logic              frame_q, frame_d;

  // Two-flop synchroniser; resets to all-ones so the idle bus looks like "no digit driven".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      pair_q <= '1;
    end else begin
      sync_q <= {seg, dig_n};
      pair_q <= sync_q;
    end
  end

  assign pair_seg = pair_q[PW-1:NDIG];
  assign pair_dig = pair_q[NDIG-1:0];
  // The pair about to be loaded differs from the current one: P changes on this edge.
  assign changed  = (sync_q != pair_q);

  always_comb begin
    n_low = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!pair_dig[i]) begin
        n_low = n_low + 4'd1;
      end
    end
  end

  assign one_low = (n_low == 4'd1);
  assign accept  = (cnt_q == CntMax) && armed_q && one_low;

  // A change always wins over a pending threshold, restarting the episode.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (changed) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (accept) begin
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  seg7_to_hex u_dec (
    .seg      (pair_seg),
    .hex      (dec_hex),
    .legal    (dec_legal),
    .is_blank (dec_blank)
  );

  assign outcome = classify(dec_legal, dec_blank);

  // Only the single low digit enable is touched, so no index decode is needed.
  always_comb begin
    hex_d    = hex_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_set = seen_q;
    for (int i = 0; i < NDIG; i++) begin
      if (accept && !pair_dig[i]) begin
        seen_set[i] = 1'b1;
        unique case (outcome)
          OutLegal: begin
            hex_d[4*i +: 4] = dec_hex;
            valid_d[i]      = 1'b1;
            blank_d[i]      = 1'b0;
          end
          OutBlank: begin
            blank_d[i] = 1'b1;
          end
          default: begin
            err_d[i] = 1'b1;
          end
        endcase
      end
    end
    upd_d   = accept;
    frame_d = accept && (&seen_set);
    seen_d  = frame_d ? '0 : seen_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q   <= '0;
      valid_q <= '0;
      blank_q <= '0;
      err_q   <= '0;
      seen_q  <= '0;
      upd_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hex_q   <= hex_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      upd_q   <= upd_d;
      frame_q <= frame_d;
    end
  end

  assign hex   = hex_q;
  assign valid = valid_q;
  assign blank = blank_q;
  assign err   = err_q;
  assign upd   = upd_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: run-length reference model plus directed tests.
module tb_seg7_scan_capture;

  localparam int NDIG       = 4;
  localparam int STABLE_CYC = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [6:0]        seg = 7'h7f;
  logic [NDIG-1:0]   dig_n = '1;
  logic [4*NDIG-1:0] hex;
  logic [NDIG-1:0]   valid, blank, err;
  logic              upd, frame;

  int n_pass  = 0;
  int n_total = 0;
  int upd_cnt = 0;
  int frame_cnt = 0;

  seg7_scan_capture #(
    .NDIG       (NDIG),
    .STABLE_CYC (STABLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg   (seg),
    .dig_n (dig_n),
    .hex   (hex),
    .valid (valid),
    .blank (blank),
    .err   (err),
    .upd   (upd),
    .frame (frame)
  );

  always #5 clk = ~clk;

  // Reference code table, index = hex value.
  logic [6:0] code_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Returns hex value, -2 for blank, -1 for an undecodable pattern.
  function automatic int decode_m(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (code_tab[i] == s) return i;
    end
    if (s == 7'b1111111) return -2;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: pin pair seen one and two edges ago, run length of identical P values.
  logic [6:0]        m_s_seg = 7'h7f, m_p_seg = 7'h7f;
  logic [NDIG-1:0]   m_s_dig = '1, m_p_dig = '1;
  int                m_run = 1;
  bit                m_taken = 0;
  logic [4*NDIG-1:0] e_hex = '0;
  logic [NDIG-1:0]   e_valid = '0, e_blank = '0, e_err = '0, m_seen = '0;
  logic              e_upd = 1'b0, e_frame = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s_seg = 7'h7f; m_p_seg = 7'h7f; m_s_dig = '1; m_p_dig = '1;
        m_run = 1; m_taken = 0;
        e_hex = '0; e_valid = '0; e_blank = '0; e_err = '0; m_seen = '0;
        e_upd = 1'b0; e_frame = 1'b0;
      end else begin
        e_upd = 1'b0;
        e_frame = 1'b0;
        if (m_run >= STABLE_CYC && !m_taken && $countones(~m_p_dig) == 1) begin
          int k;
          int d;
          k = 0;
          for (int i = 0; i < NDIG; i++) if (!m_p_dig[i]) k = i;
          m_taken = 1;
          e_upd = 1'b1;
          d = decode_m(m_p_seg);
          if (d >= 0) begin
            e_hex[4*k +: 4] = d[3:0];
            e_valid[k] = 1'b1;
            e_blank[k] = 1'b0;
          end else if (d == -2) begin
            e_blank[k] = 1'b1;
          end else begin
            e_err[k] = 1'b1;
          end
          m_seen[k] = 1'b1;
          if (&m_seen) begin
            e_frame = 1'b1;
            m_seen = '0;
          end
        end
        if ({m_s_seg, m_s_dig} != {m_p_seg, m_p_dig}) begin
          m_run = 1;
          m_taken = 0;
        end else if (m_run < 1000) begin
          m_run++;
        end
        m_p_seg = m_s_seg; m_p_dig = m_s_dig;
        m_s_seg = seg;     m_s_dig = dig_n;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("cyc_hex",   32'(hex),   32'(e_hex));
      chk("cyc_valid", 32'(valid), 32'(e_valid));
      chk("cyc_blank", 32'(blank), 32'(e_blank));
      chk("cyc_err",   32'(err),   32'(e_err));
      chk("cyc_upd",   32'(upd),   32'(e_upd));
      chk("cyc_frame", 32'(frame), 32'(e_frame));
      if (upd === 1'b1) upd_cnt++;
      if (frame === 1'b1) frame_cnt++;
    end
  end

  task automatic hold(input logic [6:0] s, input logic [NDIG-1:0] d, input int n);
    seg = s;
    dig_n = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    seg = 7'b0110000;
    dig_n = 4'b1110;
    #2;
    chk("rst_hex",   32'(hex),   32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_upd",   32'(upd),   32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: held pair, UPD after edge 6 only.
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      chk("t1_upd_edge", 32'(upd), 32'(e == 6));
    end
    @(negedge clk);
    chk("t1_hex0",  32'(hex[3:0]), 32'h3);
    chk("t1_valid", 32'(valid),    32'h1);
    upd_cnt = 0;
    repeat (10) @(negedge clk);
    chk("t1_single_upd", 32'(upd_cnt), 32'h0);

    // Test 2: full scan.
    upd_cnt = 0;
    frame_cnt = 0;
    hold(7'b1111001, 4'b1110, 6);
    hold(7'b0001000, 4'b1101, 6);
    hold(7'b1011000, 4'b1011, 6);
    hold(7'b0001110, 4'b0111, 6);
    chk("t2_hex",   32'(hex),       32'hF7A1);
    chk("t2_valid", 32'(valid),     32'hF);
    chk("t2_upds",  32'(upd_cnt),   32'd4);
    chk("t2_frame", 32'(frame_cnt), 32'd1);

    // Test 3: blank then illegal on digit 1.
    hold(7'b1111111, 4'b1101, 8);
    chk("t3_blank", 32'(blank),    32'h2);
    chk("t3_hex1",  32'(hex[7:4]), 32'hA);
    chk("t3_valid", 32'(valid),    32'hF);
    hold(7'b1111110, 4'b1101, 8);
    chk("t3_err",   32'(err),      32'h2);
    chk("t3_hex",   32'(hex),      32'hF7A1);

    // Test 4: multi-low and all-high digit enables.
    upd_cnt = 0;
    hold(7'b1000000, 4'b1100, 20);
    hold(7'b1000000, 4'b1111, 20);
    chk("t4_no_upd", 32'(upd_cnt), 32'h0);
    chk("t4_hex",    32'(hex),     32'hF7A1);
    chk("t4_blank",  32'(blank),   32'h2);
    chk("t4_err",    32'(err),     32'h2);

    // Test 5: pattern toggling faster than the stability window.
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      hold((i % 2 == 0) ? 7'b0100100 : 7'b0010010, 4'b1110, 3);
    end
    chk("t5_toggle_no_upd", 32'(upd_cnt), 32'h0);
    hold(7'b0010010, 4'b1110, 12);
    chk("t5_one_upd", 32'(upd_cnt), 32'd1);
    chk("t5_hex",     32'(hex),     32'hF7A5);

    // Test 6: asynchronous reset with the counter at 2.
    hold(7'b0000000, 4'b1011, 4);
    rst_n = 1'b0;
    #1;
    chk("t6_hex",   32'(hex),   32'h0);
    chk("t6_valid", 32'(valid), 32'h0);
    chk("t6_blank", 32'(blank), 32'h0);
    chk("t6_err",   32'(err),   32'h0);
    chk("t6_upd",   32'(upd),   32'h0);
    chk("t6_frame", 32'(frame), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      chk("t6_upd_edge", 32'(upd), 32'(e == 6));
    end
    @(negedge clk);
    chk("t6_hex_after",   32'(hex),   32'h0800);
    chk("t6_valid_after", 32'(valid), 32'h4);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
